note_gen_multi: RTL and testbench

//  Parametrised N-channel square-wave tone generator: per-channel clock divider, 4-bit volume,

---
 rtl/note_gen_multi_if.sv | 15 +
 rtl/note_gen_multi.sv | 107 ++++++++++
 tb/tb_note_gen_multi.sv | 139 +++++++++++++
 3 files changed

// File: rtl/note_gen_multi_if.sv
// Control/audio bundle for note_gen_multi: dividers and volumes in, PCM samples out.
// The master side is the melody/sensor controller; the slave side is the tone generator.
interface note_gen_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 22,
  parameter int AMP_W  = 16
);
  logic [NUM_CH*DIV_W-1:0] note_div;
  logic [NUM_CH*4-1:0]     vol;
  logic [NUM_CH*AMP_W-1:0] audio;
  logic [AMP_W-1:0]        mix_out;

  modport master (output note_div, output vol, input audio, input mix_out);
  modport slave  (input note_div, input vol, output audio, output mix_out);
endinterface

// File: rtl/note_gen_multi.sv
// N-channel square-wave tone generator with shadowed dividers and 4-bit volume.
// Define NOTE_GEN_MIX_EN to build the saturating mono mixer; otherwise mix_out is tied to 0.
module note_gen_multi #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 22,
  parameter int AMP_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  note_gen_multi_if.slave  bus
);

  localparam logic [AMP_W-2:0] AMP_MAX = '1;

`ifdef NOTE_GEN_MIX_EN
  logic signed [AMP_W-1:0] audio_ch [NUM_CH];
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0]        div_act;
    logic [DIV_W-1:0]        cnt;
    logic                    phase;
    logic signed [AMP_W-1:0] audio_q;
    logic [DIV_W-1:0]        div_in;
    logic [3:0]              vol_in;
    logic [AMP_W-2:0]        amp;
    logic signed [AMP_W-1:0] amp_pos;
    logic                    silent;
    logic                    wrap;

    assign div_in  = bus.note_div[i*DIV_W +: DIV_W];
    assign vol_in  = bus.vol[i*4 +: 4];
    assign amp     = AMP_MAX >> (4'd15 - vol_in);
    assign amp_pos = {1'b0, amp};
    assign silent  = (div_act <= DIV_W'(1));
    assign wrap    = (cnt == div_act);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        div_act <= '0;
        cnt     <= '0;
        phase   <= 1'b0;
        audio_q <= '0;
      end else begin
        // A new divider is only taken at a half-period boundary, so edits never shorten a half cycle.
        if (silent) begin
          div_act <= div_in;
          cnt     <= '0;
          phase   <= 1'b0;
        end else if (wrap) begin
          div_act <= div_in;
          cnt     <= '0;
          phase   <= (div_in <= DIV_W'(1)) ? 1'b0 : ~phase;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (silent)
          audio_q <= '0;
        else if (phase)
          audio_q <= amp_pos;
        else
          audio_q <= -amp_pos;
      end
    end

    assign bus.audio[i*AMP_W +: AMP_W] = audio_q;
`ifdef NOTE_GEN_MIX_EN
    assign audio_ch[i] = audio_q;
`endif
  end

`ifdef NOTE_GEN_MIX_EN
  localparam int SUM_W = AMP_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] POS_LIM = SUM_W'(AMP_MAX);
  localparam logic signed [SUM_W-1:0] NEG_LIM = -POS_LIM;

  logic signed [SUM_W-1:0] sum;
  logic signed [AMP_W-1:0] mix_q;

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum = sum + SUM_W'(audio_ch[i]);
  end

  // Symmetric clamp: the most negative code is never produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mix_q <= '0;
    else if (sum > POS_LIM)
      mix_q <= POS_LIM[AMP_W-1:0];
    else if (sum < NEG_LIM)
      mix_q <= NEG_LIM[AMP_W-1:0];
    else
      mix_q <= sum[AMP_W-1:0];
  end

  assign bus.mix_out = mix_q;
`else
  assign bus.mix_out = '0;
`endif

endmodule

// File: tb/tb_note_gen_multi.sv
// Directed self-checking bench for note_gen_multi (NUM_CH=2): reset, tone, shadowing,
// silence, volume, async reset and mixing; mix expectations depend on NOTE_GEN_MIX_EN.
module tb_note_gen_multi;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 22;
  localparam int AMP_W  = 16;
  localparam int M      = 32767;
`ifdef NOTE_GEN_MIX_EN
  localparam bit MIX = 1'b1;
`else
  localparam bit MIX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  note_gen_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .AMP_W(AMP_W)) bus ();

  note_gen_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .AMP_W(AMP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] aud(int ch);
    logic signed [AMP_W-1:0] s;
    s = bus.audio[ch*AMP_W +: AMP_W];
    return 32'(s);
  endfunction

  function automatic logic signed [31:0] mix();
    logic signed [AMP_W-1:0] s;
    s = bus.mix_out;
    return 32'(s);
  endfunction

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_div(int ch, int val);
    bus.note_div[ch*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  // ch1 silent: mix_out should be ch0 audio one clock later.
  task automatic run1(string tag, int n, int exp0);
    logic signed [31:0] prev;
    for (int k = 0; k < n; k++) begin
      prev = aud(0);
      @(negedge clk);
      check($sformatf("%s.a0[%0d]", tag, k), aud(0), exp0);
      check($sformatf("%s.a1[%0d]", tag, k), aud(1), 0);
      check($sformatf("%s.mix[%0d]", tag, k), mix(), MIX ? prev : 0);
    end
  endtask

  // Both channels driven identically.
  task automatic run2(string tag, int n, int expa, int expm);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s.a0[%0d]", tag, k), aud(0), expa);
      check($sformatf("%s.a1[%0d]", tag, k), aud(1), expa);
      check($sformatf("%s.mix[%0d]", tag, k), mix(), MIX ? expm : 0);
    end
  endtask

  initial begin
    bus.note_div = '0;
    bus.vol      = 8'hFF;
    set_div(0, 3);

    // Reset held with a live divider
    repeat (2) @(negedge clk);
    check("rst.a0", aud(0), 0);
    check("rst.a1", aud(1), 0);
    check("rst.mix", mix(), 0);
    rst = 1'b1;

    // Release: adopt on cycle 1, first sample on cycle 2, period 8
    run1("rel", 1, 0);
    run1("tone_n0", 4, -M);
    run1("tone_p0", 4, M);
    run1("tone_n1", 4, -M);

    // Shadow: divider changed at cnt=1 of the positive half
    run1("shd_p0", 1, M);
    set_div(0, 7);
    run1("shd_p1", 3, M);
    run1("shd_n8", 8, -M);
    run1("shd_p8", 1, M);

    // Silence adopted at the next wrap
    set_div(0, 1);
    run1("sil_p", 7, M);
    run1("sil_0", 2, 0);

    // Volume 0 then 14
    set_div(0, 3);
    bus.vol[3:0] = 4'd0;
    run1("vol0", 6, 0);
    bus.vol[3:0] = 4'd14;
    run1("vol14_p", 3, 16383);
    run1("vol14_n", 4, -16383);
    run1("arst_pre", 2, 16383);

    // Async reset at cnt=2, phase=1, between clock edges
    #2 rst = 1'b0;
    #1;
    check("arst.a0", aud(0), 0);
    check("arst.a1", aud(1), 0);
    check("arst.mix", mix(), 0);
    bus.vol = 8'hFF;
    set_div(0, 3);
    set_div(1, 3);
    @(negedge clk);
    check("arst_hold.a0", aud(0), 0);
    rst = 1'b1;

    // Restart from phase 0 with both channels in phase; mix saturates
    run2("rs_adopt", 1, 0, 0);
    run2("rs_first", 1, -M, 0);
    run2("mix_n", 3, -M, -M);
    run2("mix_np", 1, M, -M);
    run2("mix_p", 3, M, M);
    run2("mix_pn", 1, -M, M);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
